// File: rtl/joy_pkg.sv
// Shared definitions for the joystick axis decoder: zone codes and the
// per-axis debounce state codes.
package joy_pkg;

    // Zone codes; 5..7 are reserved and never driven.
    typedef enum logic [2:0] {
        CENTER = 3'd0,
        NEG_L  = 3'd1,
        NEG_H  = 3'd2,
        POS_L  = 3'd3,
        POS_H  = 3'd4
    } zone_t;

    // Per-axis debounce state.
    typedef enum logic [1:0] {
        INIT   = 2'd0,
        STABLE = 2'd1,
        PEND   = 2'd2
    } axis_state_t;

    localparam int ZONE_W = 3;

endpackage

// File: rtl/joy_axis_filter.sv
// One joystick axis: zone classification, debounce state machine and
// sample watchdog. Define JOY_HYST_EN to push the thresholds around the
// committed zone outwards by HYST LSBs; otherwise the raw thresholds apply.
module joy_axis_filter
    import joy_pkg::*;
#(
    parameter int DW         = 8,
    parameter int NEG_H_TH   = 20,
    parameter int CTR_LO     = 100,
    parameter int CTR_HI     = 150,
    parameter int POS_H_TH   = 240,
    parameter int DB_SAMPLES = 4,
    parameter int HYST       = 4,
    parameter int TO_CYCLES  = 1000000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          smp_vld,
    input  logic [DW-1:0] raw,
    output zone_t         zone,
    output logic          zone_chg,
    output logic          stale
);

    localparam int MAXV  = (1 << DW) - 1;
    localparam int CNT_W = $clog2(DB_SAMPLES + 1);
    localparam int WD_W  = (TO_CYCLES > 0) ? $clog2(TO_CYCLES + 1) : 1;

`ifdef JOY_HYST_EN
    localparam int HYST_EFF = HYST;
`else
    // Zero margin leaves every threshold at its raw value.
    localparam int HYST_EFF = 0 * HYST;
`endif

    localparam logic [DW-1:0]    HYST_V  = (HYST_EFF > MAXV) ? {DW{1'b1}} : DW'(HYST_EFF);
    localparam logic [DW-1:0]    T_NH    = DW'(NEG_H_TH);
    localparam logic [DW-1:0]    T_LO    = DW'(CTR_LO);
    localparam logic [DW-1:0]    T_HI    = DW'(CTR_HI);
    localparam logic [DW-1:0]    T_PH    = DW'(POS_H_TH);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_SAMPLES - 1);
    localparam logic [WD_W-1:0]  WD_MAX  = WD_W'(TO_CYCLES);

    function automatic logic [DW-1:0] sat_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[DW] ? {DW{1'b1}} : sum[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] sat_sub(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return (b > a) ? '0 : (a - b);
    endfunction

    axis_state_t      state;
    zone_t            cand;
    zone_t            cls;
    logic [CNT_W-1:0] cnt;
    logic [WD_W-1:0]  wd_cnt;
    logic             wd_expire;
    logic [DW-1:0]    t_nh, t_lo, t_hi, t_ph;

    // Classify the captured sample; thresholds bordering the committed zone
    // move outwards so that leaving it takes extra travel.
    always_comb begin
        t_nh = T_NH;
        t_lo = T_LO;
        t_hi = T_HI;
        t_ph = T_PH;
        if (state != INIT) begin
            unique case (zone)
                NEG_H:  t_nh = sat_add(T_NH, HYST_V);
                NEG_L:  begin t_nh = sat_sub(T_NH, HYST_V); t_lo = sat_add(T_LO, HYST_V); end
                CENTER: begin t_lo = sat_sub(T_LO, HYST_V); t_hi = sat_add(T_HI, HYST_V); end
                POS_L:  begin t_hi = sat_sub(T_HI, HYST_V); t_ph = sat_add(T_PH, HYST_V); end
                POS_H:  t_ph = sat_sub(T_PH, HYST_V);
                default: ;
            endcase
        end
        if (raw < t_nh)       cls = NEG_H;
        else if (raw < t_lo)  cls = NEG_L;
        else if (raw < t_hi)  cls = CENTER;
        else if (raw <= t_ph) cls = POS_L;
        else                  cls = POS_H;
    end

    // Watchdog fires once when the idle count reaches TO_CYCLES; a sample in
    // the same cycle takes priority.
    assign wd_expire = (TO_CYCLES != 0) && !smp_vld && (wd_cnt == WD_MAX - WD_W'(1));

    // Stage p2: debounce state machine and watchdog.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= INIT;
            zone     <= CENTER;
            cand     <= CENTER;
            cnt      <= '0;
            zone_chg <= 1'b0;
            stale    <= 1'b0;
            wd_cnt   <= '0;
        end else begin
            zone_chg <= 1'b0;
            if (smp_vld) begin
                wd_cnt <= '0;
                stale  <= 1'b0;
                unique case (state)
                    INIT: begin
                        zone     <= cls;
                        zone_chg <= (cls != CENTER);
                        cnt      <= '0;
                        state    <= STABLE;
                    end
                    STABLE: begin
                        if (cls == zone) begin
                            cnt <= '0;
                        end else if (DB_SAMPLES == 1) begin
                            zone     <= cls;
                            zone_chg <= 1'b1;
                        end else begin
                            cand  <= cls;
                            cnt   <= CNT_W'(1);
                            state <= PEND;
                        end
                    end
                    PEND: begin
                        if (cls == zone) begin
                            cnt   <= '0;
                            state <= STABLE;
                        end else if (cls == cand) begin
                            if (cnt == DB_LAST) begin
                                zone     <= cand;
                                zone_chg <= 1'b1;
                                cnt      <= '0;
                                state    <= STABLE;
                            end else begin
                                cnt <= cnt + CNT_W'(1);
                            end
                        end else begin
                            cand <= cls;
                            cnt  <= CNT_W'(1);
                        end
                    end
                    default: state <= INIT;
                endcase
            end else if (wd_expire) begin
                wd_cnt   <= wd_cnt + WD_W'(1);
                stale    <= 1'b1;
                zone     <= CENTER;
                zone_chg <= (zone != CENTER);
                cnt      <= '0;
                state    <= INIT;
            end else if ((TO_CYCLES != 0) && (wd_cnt != WD_MAX)) begin
                wd_cnt <= wd_cnt + WD_W'(1);
            end
        end
    end

endmodule

// File: rtl/joy_axis_decoder.sv
// N-axis joystick decoder: captures ADC results per channel and runs one
// joy_axis_filter per axis. Optional hysteresis via JOY_HYST_EN.
module joy_axis_decoder
    import joy_pkg::*;
#(
    parameter int DW         = 8,
    parameter int NCH        = 2,
    parameter int CH_W       = 3,
    parameter int NEG_H_TH   = 20,
    parameter int CTR_LO     = 100,
    parameter int CTR_HI     = 150,
    parameter int POS_H_TH   = 240,
    parameter int DB_SAMPLES = 4,
    parameter int HYST       = 4,
    parameter int TO_CYCLES  = 1000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CH_W-1:0]       s,
    input  logic                  eoc,
    input  logic [DW-1:0]         dout,
    output logic [DW*NCH-1:0]     raw_o,
    output logic [ZONE_W*NCH-1:0] zone_o,
    output logic [NCH-1:0]        zone_chg_o,
    output logic [NCH-1:0]        stale_o,
    output logic                  center_all_o
);

    logic [NCH-1:0] hit;
    logic [NCH-1:0] vld_p1;
    logic [DW-1:0]  raw_p1  [NCH];
    zone_t          zone_p2 [NCH];

    // Channel decode: axis i owns channel select value i+1.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            hit[i] = eoc && (s == CH_W'(i + 1));
        end
    end

    // Stage p1: capture the conversion result for the selected axis.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= '0;
            for (int i = 0; i < NCH; i++) raw_p1[i] <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                vld_p1[i] <= hit[i];
                if (hit[i]) raw_p1[i] <= dout;
            end
        end
    end

    for (genvar gi = 0; gi < NCH; gi++) begin : g_axis
        joy_axis_filter #(
            .DW         (DW),
            .NEG_H_TH   (NEG_H_TH),
            .CTR_LO     (CTR_LO),
            .CTR_HI     (CTR_HI),
            .POS_H_TH   (POS_H_TH),
            .DB_SAMPLES (DB_SAMPLES),
            .HYST       (HYST),
            .TO_CYCLES  (TO_CYCLES)
        ) u_filter (
            .clk      (clk),
            .rst      (rst),
            .smp_vld  (vld_p1[gi]),
            .raw      (raw_p1[gi]),
            .zone     (zone_p2[gi]),
            .zone_chg (zone_chg_o[gi]),
            .stale    (stale_o[gi])
        );

        assign raw_o[gi*DW +: DW]          = raw_p1[gi];
        assign zone_o[gi*ZONE_W +: ZONE_W] = zone_p2[gi];
    end

    // All axes centred and live.
    always_comb begin
        center_all_o = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            if ((zone_p2[i] != CENTER) || stale_o[i]) center_all_o = 1'b0;
        end
    end

endmodule
